// File: rtl/difftest_commit_ctrl.sv
// Commit sequencer between writeback and the difftest trace port: buffers retired
// instructions in a FIFO, drains one per handshake, and halts once an ebreak has drained.
module difftest_commit_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_inst,
  input  logic [4:0]      wb_rd,
  input  logic            wb_wen,
  input  logic [XLEN-1:0] wb_wdata,
  input  logic            wb_ebreak,
  output logic            stall_out,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_inst,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_wdata,
  output logic            trace_wen,
  output logic [63:0]     commit_cnt,
  output logic            halted,
  output logic [XLEN-1:0] halt_pc,
  output logic            overflow
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q    [DEPTH];
  logic [31:0]       inst_q  [DEPTH];
  logic [4:0]        rd_q    [DEPTH];
  logic              wen_q   [DEPTH];
  logic [XLEN-1:0]   wdata_q [DEPTH];
  logic              eb_q    [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic [63:0]       commit_cnt_q;
  logic [XLEN-1:0]   halt_pc_q;
  logic              overflow_q;
  logic              accept, push, pop, halt_pop;

  assign accept   = (state_q == RUN) && (count_q != FULL);
  assign push     = wb_valid && accept;
  assign pop      = trace_valid && trace_ready;
  assign halt_pop = (state_q == DRAIN) && pop && eb_q[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (push && wb_ebreak) state_d = DRAIN;
      DRAIN:   if (halt_pop)          state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_out = (count_q == FULL) || (state_q != RUN);
    halted    = (state_q == HALT);
  end

  // Storage is cleared on reset so the head fields read as zero while empty after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        rd_q[i]    <= '0;
        wen_q[i]   <= 1'b0;
        wdata_q[i] <= '0;
        eb_q[i]    <= 1'b0;
      end
    end else if (push) begin
      pc_q[wr_ptr_q]    <= wb_pc;
      inst_q[wr_ptr_q]  <= wb_inst;
      rd_q[wr_ptr_q]    <= wb_rd;
      wen_q[wr_ptr_q]   <= wb_wen;
      wdata_q[wr_ptr_q] <= wb_wdata;
      eb_q[wr_ptr_q]    <= wb_ebreak;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      commit_cnt_q <= '0;
      halt_pc_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + AW'(1);
        commit_cnt_q <= commit_cnt_q + 64'd1;
      end
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      if (wb_valid && !accept) overflow_q <= 1'b1;
      if (halt_pop) halt_pc_q <= pc_q[rd_ptr_q];
    end
  end

  assign trace_valid = (count_q != '0);
  assign trace_pc    = pc_q[rd_ptr_q];
  assign trace_inst  = inst_q[rd_ptr_q];
  assign trace_rd    = rd_q[rd_ptr_q];
  assign trace_wdata = wdata_q[rd_ptr_q];
  assign trace_wen   = wen_q[rd_ptr_q] && (rd_q[rd_ptr_q] != 5'd0);
  assign commit_cnt  = commit_cnt_q;
  assign halt_pc     = halt_pc_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// Bench for difftest_commit_ctrl: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_difftest_commit_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            wb_valid = 1'b0, wb_wen = 1'b0, wb_ebreak = 1'b0, trace_ready = 1'b0;
  logic [XLEN-1:0] wb_pc = '0, wb_wdata = '0;
  logic [31:0]     wb_inst = '0;
  logic [4:0]      wb_rd = '0;
  logic            stall_out, trace_valid, trace_wen, halted, overflow;
  logic [XLEN-1:0] trace_pc, trace_wdata, halt_pc;
  logic [31:0]     trace_inst;
  logic [4:0]      trace_rd;
  logic [63:0]     commit_cnt;

  difftest_commit_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
    .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_wdata(wb_wdata), .wb_ebreak(wb_ebreak),
    .stall_out(stall_out), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_rd(trace_rd),
    .trace_wdata(trace_wdata), .trace_wen(trace_wen), .commit_cnt(commit_cnt),
    .halted(halted), .halt_pc(halt_pc), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of retired instructions plus a few status flags.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] wd;
    logic        eb;
  } ent_t;

  ent_t        mq[$];
  bit          m_drain, m_halt, m_ovf;
  logic [63:0] m_cnt, m_hpc;

  function automatic void model_reset();
    mq.delete();
    m_drain = 0; m_halt = 0; m_ovf = 0;
    m_cnt = '0; m_hpc = '0;
  endfunction

  function automatic void model_edge();
    bit   acc, do_pop;
    ent_t h, e;
    acc    = !m_drain && !m_halt && (mq.size() < DEPTH);
    do_pop = (mq.size() != 0) && trace_ready;
    if (do_pop) begin
      h = mq.pop_front();
      m_cnt++;
      if (h.eb) begin
        m_halt = 1;
        m_hpc  = h.pc;
      end
    end
    if (wb_valid) begin
      if (acc) begin
        e = '{pc: wb_pc, inst: wb_inst, rd: wb_rd, wen: wb_wen, wd: wb_wdata, eb: wb_ebreak};
        mq.push_back(e);
        if (wb_ebreak) m_drain = 1;
      end else begin
        m_ovf = 1;
      end
    end
  endfunction

  task automatic check_model();
    chk("stall", stall_out, 64'(mq.size() == DEPTH || m_drain || m_halt));
    chk("trace_valid", trace_valid, 64'(mq.size() != 0));
    chk("commit_cnt", commit_cnt, m_cnt);
    chk("halted", halted, 64'(m_halt));
    chk("halt_pc", halt_pc, m_hpc);
    chk("overflow", overflow, 64'(m_ovf));
    if (mq.size() != 0) begin
      chk("trace_pc", trace_pc, mq[0].pc);
      chk("trace_inst", trace_inst, 64'(mq[0].inst));
      chk("trace_rd", trace_rd, 64'(mq[0].rd));
      chk("trace_wdata", trace_wdata, mq[0].wd);
      chk("trace_wen", trace_wen, 64'(mq[0].wen && mq[0].rd != 5'd0));
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_stall", stall_out, 0);
    chk("rst_valid", trace_valid, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_inst", 64'(trace_inst), 0);
    chk("rst_rd", 64'(trace_rd), 0);
    chk("rst_wdata", trace_wdata, 0);
    chk("rst_wen", trace_wen, 0);
    chk("rst_cnt", commit_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_halt_pc", halt_pc, 0);
    chk("rst_ovf", overflow, 0);
  endtask

  // Drive inputs just after a falling edge, clock once, resample at the next falling edge.
  task automatic apply(input bit v, input logic [63:0] pc, input logic [4:0] rd, input bit wen,
                       input logic [63:0] wd, input bit eb, input bit rdy);
    wb_valid = v; wb_pc = pc; wb_inst = pc[31:0] ^ 32'h0000_0013; wb_rd = rd;
    wb_wen = wen; wb_wdata = wd; wb_ebreak = eb; trace_ready = rdy;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic step(input bit v, input logic [63:0] pc, input logic [4:0] rd, input bit wen,
                      input logic [63:0] wd, input bit eb, input bit rdy);
    apply(v, pc, rd, wen, wd, eb, rdy);
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    wb_valid = 0; wb_ebreak = 0; trace_ready = 0;
    #1;
    model_reset();
    check_reset_vals();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    bit v; logic [63:0] pc; logic [4:0] rd; bit wen; logic [63:0] wd; bit rdy;
    bit etv; logic [63:0] epc; logic [4:0] erd; bit ewen; logic [63:0] ewd;
    bit estall; bit eovf; logic [63:0] ecnt;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 64'h1000, 5'd1, 1, 64'h11,   0, 1, 64'h1000, 5'd1, 1, 64'h11,   0, 0, 0};
    tbl[1]  = '{1, 64'h1004, 5'd2, 1, 64'h22,   0, 1, 64'h1000, 5'd1, 1, 64'h11,   0, 0, 0};
    tbl[2]  = '{1, 64'h1008, 5'd3, 1, 64'h33,   0, 1, 64'h1000, 5'd1, 1, 64'h11,   0, 0, 0};
    tbl[3]  = '{1, 64'h100c, 5'd4, 1, 64'h44,   0, 1, 64'h1000, 5'd1, 1, 64'h11,   1, 0, 0};
    tbl[4]  = '{1, 64'h1010, 5'd5, 1, 64'h55,   0, 1, 64'h1000, 5'd1, 1, 64'h11,   1, 1, 0};
    tbl[5]  = '{0, 64'h0,    5'd0, 0, 64'h0,    1, 1, 64'h1004, 5'd2, 1, 64'h22,   0, 1, 1};
    tbl[6]  = '{0, 64'h0,    5'd0, 0, 64'h0,    1, 1, 64'h1008, 5'd3, 1, 64'h33,   0, 1, 2};
    tbl[7]  = '{0, 64'h0,    5'd0, 0, 64'h0,    1, 1, 64'h100c, 5'd4, 1, 64'h44,   0, 1, 3};
    tbl[8]  = '{0, 64'h0,    5'd0, 0, 64'h0,    1, 0, 64'h0,    5'd0, 0, 64'h0,    0, 1, 4};
    tbl[9]  = '{1, 64'h2000, 5'd0, 1, 64'hdead, 0, 1, 64'h2000, 5'd0, 0, 64'hdead, 0, 1, 4};
    tbl[10] = '{1, 64'h2004, 5'd5, 1, 64'h1234, 1, 1, 64'h2004, 5'd5, 1, 64'h1234, 0, 1, 5};
    tbl[11] = '{0, 64'h0,    5'd0, 0, 64'h0,    1, 0, 64'h0,    5'd0, 0, 64'h0,    0, 1, 6};

    model_reset();
    reset = 1'b1;
    #1;
    check_reset_vals();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Vector table: back-pressure, overflow, drain order, x0 suppression.
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].v, tbl[i].pc, tbl[i].rd, tbl[i].wen, tbl[i].wd, 1'b0, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), trace_valid, 64'(tbl[i].etv));
      chk($sformatf("tbl%0d_stall", i), stall_out, 64'(tbl[i].estall));
      chk($sformatf("tbl%0d_ovf", i), overflow, 64'(tbl[i].eovf));
      chk($sformatf("tbl%0d_cnt", i), commit_cnt, tbl[i].ecnt);
      if (tbl[i].etv) begin
        chk($sformatf("tbl%0d_pc", i), trace_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_rd", i), 64'(trace_rd), 64'(tbl[i].erd));
        chk($sformatf("tbl%0d_wen", i), trace_wen, 64'(tbl[i].ewen));
        chk($sformatf("tbl%0d_wdata", i), trace_wdata, tbl[i].ewd);
      end
    end

    // Streaming with ready high: one-cycle latency, in-order, count 3.
    do_reset();
    step(1, 64'h8000_0000, 5'd1, 1, 64'ha, 0, 1);
    chk("stream0_pc", trace_pc, 64'h8000_0000);
    step(1, 64'h8000_0004, 5'd2, 1, 64'hb, 0, 1);
    chk("stream1_pc", trace_pc, 64'h8000_0004);
    step(1, 64'h8000_0008, 5'd3, 1, 64'hc, 0, 1);
    chk("stream2_pc", trace_pc, 64'h8000_0008);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("stream_cnt", commit_cnt, 3);

    // Full FIFO with push and pop together: push refused, head advances.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 64'h3000 + 64'(4 * i), 5'(i + 1), 1, 64'(i), 0, 0);
    step(1, 64'h3010, 5'd9, 1, 64'h99, 0, 1);
    chk("fullpp_stall", stall_out, 0);
    chk("fullpp_head", trace_pc, 64'h3004);
    chk("fullpp_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);
    chk("fullpp_cnt", commit_cnt, 4);

    // Ebreak drain and halt.
    do_reset();
    step(1, 64'h8000_0000, 5'd1, 1, 64'h1, 0, 0);
    step(1, 64'h8000_0004, 5'd2, 1, 64'h2, 0, 0);
    step(1, 64'h8000_0010, 5'd0, 0, 64'h0, 1, 0);
    chk("eb_stall", stall_out, 1);
    step(1, 64'h8000_0014, 5'd3, 1, 64'h3, 0, 0);
    chk("eb_ovf", overflow, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("eb_not_yet", halted, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("eb_halted", halted, 1);
    chk("eb_halt_pc", halt_pc, 64'h8000_0010);
    chk("eb_cnt", commit_cnt, 3);
    step(1, 64'h9000, 5'd4, 1, 64'h4, 0, 1);
    chk("eb_no_push", trace_valid, 0);

    // Asynchronous reset mid-cycle while draining with two entries held.
    do_reset();
    step(1, 64'h4000, 5'd1, 1, 64'h1, 0, 0);
    step(1, 64'h4004, 5'd0, 0, 64'h0, 1, 0);
    chk("mid_stall", stall_out, 1);
    #2;
    reset = 1'b1;
    wb_valid = 0; wb_ebreak = 0;
    #1;
    model_reset();
    check_reset_vals();
    @(negedge clock);
    reset = 1'b0;
    step(1, 64'h5000, 5'd6, 1, 64'h66, 0, 0);
    chk("mid_after_pc", trace_pc, 64'h5000);

    // Randomized traffic against the model, resetting some time after each halt.
    do_reset();
    begin
      int halt_wait = 0;
      for (int n = 0; n < 800; n++) begin
        if (m_halt && ++halt_wait > 3) begin
          halt_wait = 0;
          do_reset();
        end
        step($urandom_range(99) < 65, {32'h0, $urandom}, 5'($urandom_range(31)),
             1'($urandom), {$urandom, $urandom}, $urandom_range(39) == 0,
             $urandom_range(99) < ((n / 100) % 2 == 0 ? 50 : 85));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/difftest_commit_ctrl.md
# difftest_commit_ctrl

Sequences retired-instruction commit events from the writeback stage of the 5-stage pipeline to the simulation trace/difftest port, so GPR snapshots are compared only at instruction boundaries. Buffers up to DEPTH commits in a FIFO, drains one per cycle under a valid/ready handshake, and back-pressures the pipeline when full. Detects `ebreak` retirement, drains outstanding commits, then reports halt with the halting PC.

## Interface
- DEPTH, 4, commit FIFO entries (power of two, ≥2)
- XLEN, 64, data/PC width

- clock  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_valid  in  1  an instruction retires this cycle
- wb_pc  in  XLEN  PC of retiring instruction
- wb_inst  in  32  instruction word
- wb_rd  in  5  destination GPR index
- wb_wen  in  1  GPR write enable
- wb_wdata  in  XLEN  GPR write data
- wb_ebreak  in  1  retiring instruction is `ebreak`
- stall_out  out  1  FIFO full; writeback must hold
- trace_valid  out  1  head entry available
- trace_ready  in  1  harness consumes head this cycle
- trace_pc / trace_inst / trace_rd / trace_wdata  out  XLEN/32/5/XLEN  head entry fields
- trace_wen  out  1  head GPR write enable (0 when rd==0)
- commit_cnt  out  64  number of entries popped since reset
- halted  out  1  ebreak committed and drained
- halt_pc  out  XLEN  PC of the ebreak
- overflow  out  1  sticky: wb_valid arrived while not accepting

## Operation
- FIFO: DEPTH regs, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping modulo DEPTH, count of log2(DEPTH)+1 bits.
- push = wb_valid & accept; accept = (state==RUN) & (count<DEPTH).
- pop = trace_valid & trace_ready; trace_valid = (count!=0).
- Simultaneous push and pop: count unchanged, both pointers advance; at count==DEPTH push is refused even if pop occurs (stall_out is purely count-based, no ready bypass).
- wb_valid & !accept: entry dropped, overflow set to 1 until reset.
- trace_wen = stored wen & (rd!=0); x0 writes never reported.
- commit_cnt += 1 on each pop; wraps at 2^64.
- State machine:
  - RUN: normal. Push with wb_ebreak=1 → DRAIN (the ebreak entry itself is pushed, stored ebreak bit set).
  - DRAIN: no pushes; pops continue. Pop of the entry whose ebreak bit is set → HALTED, halt_pc ← its pc.
  - HALTED: terminal until reset; halted=1, no pushes; FIFO is empty by construction.
- stall_out = (count==DEPTH) | (state!=RUN).

## Timing
- Reset values: stall_out 0, trace_valid 0, all trace_* fields 0, commit_cnt 0, halted 0, halt_pc 0, overflow 0, state RUN, pointers/count 0.
- Push at edge N → trace_valid=1 and head fields valid after edge N (visible in cycle N+1); one-cycle latency, no combinational wb→trace path.
- Head outputs are driven from FIFO storage at rd_ptr; stable while trace_valid & !trace_ready.
- halted rises on the edge that pops the ebreak entry; halt_pc updates on the same edge.
- stall_out follows count/state registers only (no combinational dependence on wb_valid or trace_ready).
- Reset asserted mid-operation: FIFO contents discarded, all outputs to reset values immediately (asynchronous).
- Throughput: one push and one pop per cycle sustained when trace_ready held high.

## Test plan
- Reset, then 3 pushes pc=0x80000000/04/08 with trace_ready=1 → trace_valid one cycle after each, pcs in order, commit_cnt=3.
- trace_ready=0, 5 consecutive wb_valid (DEPTH=4) → stall_out=1 after 4th push, 5th dropped, overflow=1; raise trace_ready → 4 entries drain in order, stall_out falls after first pop.
- Push rd=0, wen=1, wdata=0xdead → trace_wen=0, trace_rd=0; push rd=5, wen=1 → trace_wen=1, trace_wdata matches.
- Full FIFO with push and pop in same cycle → push refused, count 4→3, no data corruption; non-full push+pop → count unchanged, pointers wrap past DEPTH-1 correctly.
- Push 2 normal entries then ebreak at pc=0x80000010 with trace_ready=0 → stall_out=1, further wb_valid sets overflow; enable trace_ready → halted=1 on the 3rd pop, halt_pc=0x80000010, commit_cnt=3.
- Assert reset while FIFO holds 2 entries in DRAIN → all outputs return to reset values, state RUN, next push accepted normally.
